// File: rtl/mix_pkg.sv
// Shared types and constants for the lane-mixing sequencer and its combinational step unit.
package mix_pkg;

  localparam int unsigned Lanes = 8;
  localparam int unsigned LaneW = 32;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StAddc  = 4'd1,
    StChain = 4'd2,
    StMixa  = 4'd3,
    StMixx  = 4'd4,
    StMixs  = 4'd5,
    StFold  = 4'd6,
    StMul1  = 4'd7,
    StMul2  = 4'd8,
    StDone  = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    StepAddc,
    StepChain,
    StepMixa,
    StepMixx,
    StepMixs,
    StepFold,
    StepMul1,
    StepMul2
  } step_e;

  localparam logic [31:0] M1 [Lanes] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] C1 [Lanes] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam logic [31:0] M2 [Lanes] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam logic [31:0] C2 [Lanes] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216,
                                         32'd343};

endpackage

// File: rtl/mix_step.sv
// One datapath step: lanes update in order 0..7, each seeing the already-updated lower lanes.
module mix_step
  import mix_pkg::*;
(
  input  logic [Lanes*LaneW-1:0] state,
  input  step_e                  sel,
  output logic [Lanes*LaneW-1:0] next_state
);

  logic [31:0] o [Lanes];

  always_comb begin
    for (int i = 0; i < Lanes; i++) o[3'(i)] = state[32*i +: 32];
    // Blocking updates in a loop give the required in-cycle lane chaining.
    unique case (sel)
      StepAddc:  for (int i = 0; i < Lanes; i++) o[3'(i)] = o[3'(i)] + 32'(i);
      StepChain: for (int i = 0; i < Lanes; i++) o[3'(i)] = o[3'(i)] + o[3'(i + 7)];
      StepMixa:  for (int i = 0; i < Lanes; i++)
                   o[3'(i)] = o[3'(i)] + o[3'(i + 1)] - o[3'(i + 5)];
      StepMixx:  for (int i = 0; i < Lanes; i++) o[3'(i)] = o[3'(i)] ^ (o[3'(i + 3)] << 16);
      StepMixs:  for (int i = 0; i < Lanes; i++)
                   o[3'(i)] = o[3'(i)] - (o[3'(i + 2)] >> 17) + (o[3'(i + 4)] >> 12);
      StepFold:  for (int i = 0; i < Lanes; i++)
                   o[3'(i)] = o[3'(i)] + o[3'(i + 7)] - o[3'(i + 6)];
      StepMul1:  for (int i = 0; i < Lanes; i++) o[3'(i)] = o[3'(i)] * M1[3'(i)] + C1[3'(i)];
      StepMul2:  for (int i = 0; i < Lanes; i++) o[3'(i)] = o[3'(i)] * M2[3'(i)] + C2[3'(i)];
    endcase
    for (int i = 0; i < Lanes; i++) next_state[32*i +: 32] = o[3'(i)];
  end

endmodule

// File: rtl/mix_sequencer.sv
// Sequences the mixing steps over a 256-bit lane register with a valid/ready result handshake.
module mix_sequencer
  import mix_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [32*LANES-1:0]   seed,
  input  logic [3:0]            rounds,
  input  logic [3:0]            folds,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   result,
  output logic [3:0]            phase
);

  state_e                 state_q;
  logic [32*LANES-1:0]    lanes_q;
  logic [32*LANES-1:0]    lanes_step;
  logic [3:0]             rnd_q;
  logic [3:0]             fld_q;
  logic                   busy_q;
  logic                   valid_q;
  step_e                  sel;

  always_comb begin
    sel = StepAddc;
    case (state_q)
      StChain: sel = StepChain;
      StMixa:  sel = StepMixa;
      StMixx:  sel = StepMixx;
      StMixs:  sel = StepMixs;
      StFold:  sel = StepFold;
      StMul1:  sel = StepMul1;
      StMul2:  sel = StepMul2;
      default: sel = StepAddc;
    endcase
  end

  mix_step u_step (
    .state      (lanes_q),
    .sel        (sel),
    .next_state (lanes_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lanes_q <= '0;
      rnd_q   <= '0;
      fld_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            lanes_q <= seed;
            rnd_q   <= rounds;
            fld_q   <= folds;
            busy_q  <= 1'b1;
            state_q <= StAddc;
          end
        end
        StAddc: begin
          lanes_q <= lanes_step;
          state_q <= StChain;
        end
        StChain: begin
          lanes_q <= lanes_step;
          if (rnd_q != 4'd0)      state_q <= StMixa;
          else if (fld_q != 4'd0) state_q <= StFold;
          else                    state_q <= StMul1;
        end
        StMixa: begin
          lanes_q <= lanes_step;
          state_q <= StMixx;
        end
        StMixx: begin
          lanes_q <= lanes_step;
          state_q <= StMixs;
        end
        StMixs: begin
          lanes_q <= lanes_step;
          rnd_q   <= rnd_q - 4'd1;
          if (rnd_q != 4'd1)      state_q <= StMixa;
          else if (fld_q != 4'd0) state_q <= StFold;
          else                    state_q <= StMul1;
        end
        StFold: begin
          lanes_q <= lanes_step;
          fld_q   <= fld_q - 4'd1;
          state_q <= (fld_q != 4'd1) ? StFold : StMul1;
        end
        StMul1: begin
          lanes_q <= lanes_step;
          state_q <= StMul2;
        end
        StMul2: begin
          lanes_q <= lanes_step;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          // Start is deliberately not sampled here, even in the release cycle.
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign result    = lanes_q;
  assign phase     = state_q;

endmodule

// File: doc/mix_sequencer.md
MIX_SEQUENCER -- requirements
Module: mix_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning number of 32-bit state lanes; only value 8 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one computation.
REQ-005 SHALL have port seed  input  256  initial lane values; lane i = seed[32*i+31:32*i].
REQ-006 SHALL have port rounds  input  4  number of mix rounds, 0..15.
REQ-007 SHALL have port folds  input  4  number of fold steps, 0..15.
REQ-008 SHALL have port busy  output  1  high from accepted start until out_valid rises.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  256  final lane values, same packing as seed.
REQ-012 SHALL have port phase  output  4  current state encoding, for debug only.

Function
REQ-013 SHALL implement states IDLE, ADDC, CHAIN, MIXA, MIXX, MIXS, FOLD, MUL1, MUL2, DONE, with exactly one datapath step per cycle in each non-IDLE, non-DONE state.
REQ-014 SHALL, in IDLE with start=1, load lanes from seed, latch rounds/folds into internal counters, and go to ADDC; start SHALL be ignored in every other state.
REQ-015 SHALL sequence ADDC -> CHAIN -> (MIXA -> MIXX -> MIXS) x rounds -> FOLD x folds -> MUL1 -> MUL2 -> DONE; a zero count skips that group entirely.
REQ-016 SHALL evaluate each step as lane updates i=0..7 in order, each update using the already-updated values of lower lanes from the same cycle; all arithmetic mod 2^32; all shifts logical.
REQ-017 ADDC: o[i] = o[i] + i.
REQ-018 CHAIN: o[i] = o[i] + o[(i+7)%8].
REQ-019 MIXA: o[i] = o[i] + o[(i+1)%8] - o[(i+5)%8].
REQ-020 MIXX: o[i] = o[i] ^ (o[(i+3)%8] << 16).
REQ-021 MIXS: o[i] = o[i] - (o[(i+2)%8] >> 17) + (o[(i+4)%8] >> 12).
REQ-022 FOLD: o[i] = o[i] + o[(i+7)%8] - o[(i+6)%8].
REQ-023 MUL1: o[i] = o[i]*M1[i] + C1[i], M1={2,3,5,7,11,13,17,19}, C1={3,5,7,11,13,17,19,23}.
REQ-024 MUL2: o[i] = o[i]*M2[i] + C2[i], M2={2,3,3,3,5,13,35,87}, C2={0,1,8,27,64,125,216,343}.
REQ-025 SHALL have latency 4 + 3*rounds + folds cycles from the start-accept edge to the edge that sets out_valid.
REQ-026 In DONE, out_valid=1, busy=0, result=lanes; result SHALL stay stable while out_ready=0.
REQ-027 In DONE with out_ready=1, SHALL clear out_valid and return to IDLE on the next edge; a start in that same cycle SHALL be ignored.
REQ-028 result SHALL show the current lane register at all times; its value is meaningful only while out_valid=1.

Reset
REQ-029 rst=1 SHALL, on the next edge, force state IDLE, all lanes to 0, counters to 0, busy=0, out_valid=0, phase=IDLE encoding; reset SHALL override start.
REQ-030 Reset mid-computation SHALL abort the computation; no out_valid SHALL be produced for the aborted request.

Structure
REQ-031 A shared package mix_pkg SHALL hold the state enum, the lane count, the step-select enum and the M1/C1/M2/C2 constant tables.
REQ-032 A single combinational sub-module mix_step SHALL take the 256-bit state and the step select and return the next 256-bit state; mix_sequencer SHALL hold the FSM, counters, lane register and handshake.

Verification
REQ-033 Reset check: after rst held for 2 cycles -> busy=0, out_valid=0, result=0.
REQ-034 Baseline vector: seed=0, rounds=0, folds=0, start pulse -> out_valid rises 4 cycles after accept; result lanes 0..7 = 34, 88, 179, 333, 1064, 4064, 17541, 60199.
REQ-035 Max run: random seed, rounds=15, folds=15 -> out_valid after 64 cycles; result matches the bit-accurate golden model.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> result and out_valid stable; out_ready=1 -> out_valid=0 next cycle and state IDLE.
REQ-037 Start while busy: second start pulse 3 cycles after accept, with a different seed -> ignored; result equals that of the first request only.
REQ-038 Reset mid-op: rst asserted 10 cycles into a rounds=15 run -> next cycle IDLE, lanes 0; no out_valid observed afterwards until a new start.
